alu_arbiter: RTL

//  Shares one combinational ALU (r1/r2/sub -> sum/overflow) between NREQ requesters
//  (e.g. EXU and an address/compare unit). Round-robin arbiter plus 3-state sequencer.

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NREQ requesters.
// Define ALU_ARB_STATS_EN to enable per-requester grant counters on grant_cnt.
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [W*NREQ-1:0]    req_a,
    input  logic [W*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic                 rsp_ovf,
    output logic [W-1:0]         alu_r1,
    output logic [W-1:0]         alu_r2,
    output logic [2:0]           alu_sub,
    input  logic [W-1:0]         alu_sum,
    input  logic                 alu_overflow,
    output logic [32*NREQ-1:0]   grant_cnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   owner_q;
    logic [W-1:0]    alu_r1_q;
    logic [W-1:0]    alu_r2_q;
    logic [2:0]      alu_sub_q;
    logic [W-1:0]    rsp_data_q;
    logic            rsp_ovf_q;

    logic [PW-1:0]   cand;
    logic [PW-1:0]   win_idx;
    logic            win_found;
    logic            hs;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = PW'((32'(rr_ptr_q) + k) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign hs = (state_q == StIdle) && win_found;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ready[i] = hs && (win_idx == PW'(i));
            rsp_valid[i] = (state_q == StResp) && (owner_q == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rr_ptr_q   <= PW'(NREQ - 1);
            owner_q    <= '0;
            alu_r1_q   <= '0;
            alu_r2_q   <= '0;
            alu_sub_q  <= 3'b000;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hs) begin
                        alu_r1_q  <= req_a[W*win_idx +: W];
                        alu_r2_q  <= req_b[W*win_idx +: W];
                        alu_sub_q <= req_op[3*win_idx +: 3];
                        owner_q   <= win_idx;
                        rr_ptr_q  <= win_idx;
                        state_q   <= StExec;
                    end
                end
                StExec: begin
                    rsp_data_q <= alu_sum;
                    rsp_ovf_q  <= alu_overflow;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (rsp_ready[owner_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_r1   = alu_r1_q;
    assign alu_r2   = alu_r2_q;
    assign alu_sub  = alu_sub_q;
    assign rsp_data = rsp_data_q;
    assign rsp_ovf  = rsp_ovf_q;

`ifdef ALU_ARB_STATS_EN
    logic [32*NREQ-1:0] grant_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else if (hs) begin
            grant_cnt_q[32*win_idx +: 32] <= grant_cnt_q[32*win_idx +: 32] + 32'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule
